alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
- Operand-fetch/issue stage directly upstream of the 32-bit combinational ALU.
- Decodes a 32-bit instruction word, reads a 32x32 register file (two read ports, one write-back port) and presents registered S1, S2 and OpCode to the ALU.
- Valid/ready handshake on both sides; write-back from downstream updates the register file.

Parameters:
- NREGS, 32, number of architectural registers; r0 reads as zero, writes to r0 ignored.
- XLEN, 32, data width of registers, S1, S2 and WB_DATA.

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- IN_VALID  input  1  INSTR is valid this cycle
- IN_READY  output  1  stage accepts INSTR this cycle
- INSTR  input  32  [31:28] op, [27:23] rd, [22:18] rs1, [17:13] rs2, [12] imm_sel, [11:0] imm12
- OUT_VALID  output  1  S1/S2/OpCode/RD hold a valid issued op
- OUT_READY  input  1  downstream consumes the issued op
- S1  output  XLEN  operand 1 to ALU
- S2  output  XLEN  operand 2 to ALU
- OpCode  output  4  ALU opcode
- RD  output  5  destination register travelling with the op
- ILLEGAL  output  1  issued op has an unsupported opcode
- WB_EN  input  1  write-back strobe
- WB_RD  input  5  write-back register index
- WB_DATA  input  XLEN  write-back data

Behaviour:
- Reset (RST_N low, async): OUT_VALID=0, S1=0, S2=0, OpCode=0, RD=0, ILLEGAL=0, all registers cleared to 0. The pending table is cleared when SCOREBOARD_EN is defined.
- Legal opcodes: 0 add, 1 sll, 2 slt, 3 ugt, 4 xor, 5 srl, 6 or, 7 and, 8 sub, 13 sra.
- Opcodes 9-12, 14, 15: issued with ILLEGAL=1 and OpCode passed unchanged; the ALU outputs 0 for these.
- IN_READY = (!OUT_VALID || OUT_READY) && !stall. Without SCOREBOARD_EN, stall is 0.
- Accept: IN_VALID && IN_READY at a rising edge. On the same edge, the output registers load:
  - S1 = reg[rs1].
  - S2 = imm_sel ? sign_extend(imm12) : reg[rs2].
  - OpCode = op; RD = rd; ILLEGAL = decode flag; OUT_VALID = 1.
- Latency: one cycle from accept to OUT_VALID.
- Drain: OUT_VALID && OUT_READY with no new accept → OUT_VALID=0 next cycle. The data outputs hold their last values.
- Hold: OUT_VALID && !OUT_READY → all outputs stable; IN_READY=0.
- Full throughput: one op per cycle while OUT_READY stays high.
- Register read of index 0 → 0 regardless of any write-back.
- Write-back: WB_EN with WB_RD≠0 writes reg[WB_RD] at the edge.
- Same-cycle write-back and read of the same index: the read returns WB_DATA (write-first bypass). This applies to rs1 and rs2 independently.
- Imm12 sign extension: bit 11 is replicated to bits XLEN-1:12.
- Shift amounts and arithmetic semantics belong to the ALU; this stage only forwards the full XLEN value.
- Reset asserted mid-operation: the in-flight op is discarded immediately and OUT_VALID drops asynchronously.

Optional Feature:
- Macro: SCOREBOARD_EN
- Defined:
  - A pending bit per register is set when an op with rd≠0 is accepted, and cleared on write-back of that register.
  - stall=1 when IN_VALID and any register operand is pending. The rs1 check always applies; the rs2 check applies only when imm_sel=0.
  - A write-back in the same cycle clears the hazard, so no stall occurs (bypass covers it).
  - Simultaneous set and clear of the same rd: set wins.
- Not defined: no pending state and no stalls. Correct ordering of dependent ops is the responsibility of software.

Test Plan:
- Reset, then WB r1=0x0000_0005 and r2=0x0000_0003. Issue op=0, rd=3, rs1=1, rs2=2 → next cycle OUT_VALID=1, S1=5, S2=3, OpCode=0, RD=3, ILLEGAL=0.
- Issue op=8, rs1=1, imm_sel=1, imm12=0xFFF → S1=5, S2=0xFFFF_FFFF, OpCode=8.
- WB r4=0xDEAD_BEEF in the same cycle as accepting rs1=4, rs2=0 → S1=0xDEAD_BEEF, S2=0. Then WB r0=7 and read r0 → 0.
- Back-to-back issue of 3 ops with OUT_READY held low after the first → the first op's outputs stay stable and IN_READY=0. Raise OUT_READY → the remaining ops issue on consecutive cycles.
- Issue op=0xE → ILLEGAL=1, OpCode=0xE. Assert RST_N=0 while OUT_VALID=1 → OUT_VALID=0 immediately and all outputs 0.
- SCOREBOARD_EN: issue rd=5, then rs1=5 with no write-back → IN_READY=0 until WB_EN with WB_RD=5 (WB_DATA=0x11). The dependent op is accepted that cycle with S1=0x11.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Operand-fetch/issue stage feeding the 32-bit ALU: decode, 32xXLEN regfile, registered operands.
// Optional `SCOREBOARD_EN adds per-register pending bits that stall dependent ops until write-back.
module alu_issue_stage #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned XLEN  = 32
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [31:0]     INSTR,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] S1,
  output logic [XLEN-1:0] S2,
  output logic [3:0]      OpCode,
  output logic [4:0]      RD,
  output logic            ILLEGAL,
  input  logic            WB_EN,
  input  logic [4:0]      WB_RD,
  input  logic [XLEN-1:0] WB_DATA
);

  logic [3:0]      op;
  logic [4:0]      rd, rs1, rs2;
  logic            imm_sel;
  logic [11:0]     imm12;
  logic [XLEN-1:0] rf [NREGS];
  logic [XLEN-1:0] rs1_val, rs2_val, s2_sel;
  logic            illegal;
  logic            accept;
  logic            stall;

  assign op      = INSTR[31:28];
  assign rd      = INSTR[27:23];
  assign rs1     = INSTR[22:18];
  assign rs2     = INSTR[17:13];
  assign imm_sel = INSTR[12];
  assign imm12   = INSTR[11:0];

  assign IN_READY = (!OUT_VALID || OUT_READY) && !stall;
  assign accept   = IN_VALID && IN_READY;

  // r0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < int'(NREGS); i++) rf[i] <= '0;
    end else if (WB_EN && WB_RD != 5'd0) begin
      rf[WB_RD] <= WB_DATA;
    end
  end

  // Write-first bypass so a same-cycle write-back is visible to the issuing op.
  always_comb begin
    rs1_val = rf[rs1];
    rs2_val = rf[rs2];
    if (WB_EN && WB_RD == rs1) rs1_val = WB_DATA;
    if (WB_EN && WB_RD == rs2) rs2_val = WB_DATA;
    if (rs1 == 5'd0) rs1_val = '0;
    if (rs2 == 5'd0) rs2_val = '0;
    s2_sel = imm_sel ? {{(XLEN-12){imm12[11]}}, imm12} : rs2_val;
  end

  always_comb begin
    illegal = 1'b1;
    case (op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd13: illegal = 1'b0;
      default: illegal = 1'b1;
    endcase
  end

`ifdef SCOREBOARD_EN
  logic [NREGS-1:0] pending_q, pending_d;
  logic             haz1, haz2;

  always_comb begin
    haz1  = pending_q[rs1] && !(WB_EN && WB_RD == rs1);
    haz2  = pending_q[rs2] && !(WB_EN && WB_RD == rs2);
    stall = IN_VALID && (haz1 || (!imm_sel && haz2));
  end

  // Set is applied after clear so a new producer of the same rd wins.
  always_comb begin
    pending_d = pending_q;
    if (WB_EN) pending_d[WB_RD] = 1'b0;
    if (accept && rd != 5'd0) pending_d[rd] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) pending_q <= '0;
    else        pending_q <= pending_d;
  end
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OUT_VALID <= 1'b0;
      S1        <= '0;
      S2        <= '0;
      OpCode    <= '0;
      RD        <= '0;
      ILLEGAL   <= 1'b0;
    end else if (accept) begin
      OUT_VALID <= 1'b1;
      S1        <= rs1_val;
      S2        <= s2_sel;
      OpCode    <= op;
      RD        <= rd;
      ILLEGAL   <= illegal;
    end else if (OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule
